// File: rtl/imm_pkg.sv
// imm_pkg
// Shared constants for the immediate generator pipeline: RV32I/RV64I major
// opcodes and the 3-bit format code attached to every extracted immediate.
// No ports; imported by immediate_decode and immediate_generator_pipe.
package imm_pkg;

    // Major opcodes, INSTRUCTION[6:0]
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    // Format code presented on FORMAT
    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_CSR   = 3'd7
    } fmt_t;

endpackage

// File: rtl/immediate_decode.sv
// immediate_decode
// Purely combinational extraction of the immediate carried by one RV32I/RV64I
// instruction word, together with its format code and an illegal-encoding flag.
// Ports:
//   INSTRUCTION [31:0]     raw instruction word
//   IMMEDIATE   [XLEN-1:0] extracted immediate (sign- or zero-extended)
//   FORMAT      [2:0]      fmt_t code of the recognised format
//   ILLEGAL                shift amount not representable for this XLEN
module immediate_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     INSTRUCTION,
    output logic [XLEN-1:0] IMMEDIATE,
    output logic [2:0]      FORMAT,
    output logic            ILLEGAL
);

    // Widen a 32-bit value to XLEN by replicating its bit 31.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    // Widen a 32-bit value to XLEN with zeros.
    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{1'b0}};
        r[31:0] = v;
        return r;
    endfunction

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic            sign_s;
    logic [XLEN-1:0] imm_s;
    fmt_t            fmt_s;
    logic            ill_s;

    assign opcode_s = INSTRUCTION[6:0];
    assign funct3_s = INSTRUCTION[14:12];
    assign sign_s   = INSTRUCTION[31];

    // Format selection and field reassembly by major opcode.
    always_comb begin
        imm_s = {XLEN{1'b0}};
        fmt_s = FMT_NONE;
        ill_s = 1'b0;
        case (opcode_s)
            OP_IMM: begin
                if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                    fmt_s = FMT_SHAMT;
                    if (XLEN == 64) begin
                        imm_s = zext32({26'd0, INSTRUCTION[25:20]});
                    end else if (INSTRUCTION[25]) begin
                        // 6-bit shift amount on a 32-bit datapath
                        ill_s = 1'b1;
                        imm_s = {XLEN{1'b0}};
                    end else begin
                        imm_s = zext32({27'd0, INSTRUCTION[24:20]});
                    end
                end else begin
                    fmt_s = FMT_I;
                    imm_s = sext32({{20{sign_s}}, INSTRUCTION[31:20]});
                end
            end
            LOAD, JALR: begin
                fmt_s = FMT_I;
                imm_s = sext32({{20{sign_s}}, INSTRUCTION[31:20]});
            end
            STORE: begin
                fmt_s = FMT_S;
                imm_s = sext32({{20{sign_s}}, INSTRUCTION[31:25], INSTRUCTION[11:7]});
            end
            BRANCH: begin
                fmt_s = FMT_B;
                imm_s = sext32({{19{sign_s}}, INSTRUCTION[31], INSTRUCTION[7],
                                INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0});
            end
            LUI, AUIPC: begin
                fmt_s = FMT_U;
                imm_s = sext32({INSTRUCTION[31:12], 12'd0});
            end
            JAL: begin
                fmt_s = FMT_J;
                imm_s = sext32({{11{sign_s}}, INSTRUCTION[31], INSTRUCTION[19:12],
                                INSTRUCTION[20], INSTRUCTION[30:21], 1'b0});
            end
            SYSTEM: begin
                // Only the immediate CSR forms carry a zimm in the rs1 field
                if (funct3_s[2] && (funct3_s[1:0] != 2'b00)) begin
                    fmt_s = FMT_CSR;
                    imm_s = zext32({27'd0, INSTRUCTION[19:15]});
                end else begin
                    fmt_s = FMT_NONE;
                    imm_s = {XLEN{1'b0}};
                end
            end
            default: begin
                imm_s = {XLEN{1'b0}};
                fmt_s = FMT_NONE;
                ill_s = 1'b0;
            end
        endcase
    end

    assign IMMEDIATE = imm_s;
    assign FORMAT    = fmt_s;
    assign ILLEGAL   = ill_s;

endmodule

// File: rtl/immediate_generator_pipe.sv
// immediate_generator_pipe
// Registered immediate generator between fetch and decode/execute. Accepts one
// instruction per cycle on a valid/ready handshake, decodes its immediate and
// presents it one cycle later. An output register plus one skid register keep
// results in FIFO order under downstream stalls; IN_READY depends only on
// registered state, never on OUT_READY.
// Ports:
//   CLK, RESET (sync, active-high), FLUSH (sync discard of buffered entries)
//   IN_VALID/IN_READY, INSTRUCTION[31:0], IN_TAG[TAG_W-1:0]      input side
//   OUT_VALID/OUT_READY, IMMEDIATE[XLEN-1:0], FORMAT[2:0],
//   ILLEGAL, OUT_TAG[TAG_W-1:0]                                  output side
module immediate_generator_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      INSTRUCTION,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  IMMEDIATE,
    output logic [2:0]       FORMAT,
    output logic             ILLEGAL,
    output logic [TAG_W-1:0] OUT_TAG
);

    logic [XLEN-1:0]  dec_imm_s;
    logic [2:0]       dec_fmt_s;
    logic             dec_ill_s;
    logic             accept_s;
    logic             drain_s;

    logic             out_valid_r;
    logic [XLEN-1:0]  out_imm_r;
    logic [2:0]       out_fmt_r;
    logic             out_ill_r;
    logic [TAG_W-1:0] out_tag_r;

    logic             skid_valid_r;
    logic [XLEN-1:0]  skid_imm_r;
    logic [2:0]       skid_fmt_r;
    logic             skid_ill_r;
    logic [TAG_W-1:0] skid_tag_r;

    // Mirrors !skid_valid as a flop so IN_READY has no path from OUT_READY
    logic             in_ready_r;

    immediate_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .INSTRUCTION (INSTRUCTION),
        .IMMEDIATE   (dec_imm_s),
        .FORMAT      (dec_fmt_s),
        .ILLEGAL     (dec_ill_s)
    );

    // RESET only masks the registered ready so it reads 0 during reset and
    // 1 immediately after it is released.
    assign IN_READY = in_ready_r & ~RESET;
    assign accept_s = IN_VALID & IN_READY;
    assign drain_s  = out_valid_r & OUT_READY;

    // Output register, skid register and ready flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_r  <= 1'b0;
            out_imm_r    <= {XLEN{1'b0}};
            out_fmt_r    <= FMT_NONE;
            out_ill_r    <= 1'b0;
            out_tag_r    <= {TAG_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_imm_r   <= {XLEN{1'b0}};
            skid_fmt_r   <= FMT_NONE;
            skid_ill_r   <= 1'b0;
            skid_tag_r   <= {TAG_W{1'b0}};
            in_ready_r   <= 1'b1;
        end else if (FLUSH) begin
            // Any instruction offered in this cycle is dropped as well
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (!out_valid_r || drain_s) begin
            // Output slot is free at this edge: refill oldest-first
            if (skid_valid_r) begin
                out_valid_r  <= 1'b1;
                out_imm_r    <= skid_imm_r;
                out_fmt_r    <= skid_fmt_r;
                out_ill_r    <= skid_ill_r;
                out_tag_r    <= skid_tag_r;
                skid_valid_r <= 1'b0;
                in_ready_r   <= 1'b1;
            end else if (accept_s) begin
                out_valid_r  <= 1'b1;
                out_imm_r    <= dec_imm_s;
                out_fmt_r    <= dec_fmt_s;
                out_ill_r    <= dec_ill_s;
                out_tag_r    <= IN_TAG;
            end else begin
                out_valid_r  <= 1'b0;
            end
        end else if (accept_s) begin
            // Output stalled: park the new result in the skid slot
            skid_valid_r <= 1'b1;
            skid_imm_r   <= dec_imm_s;
            skid_fmt_r   <= dec_fmt_s;
            skid_ill_r   <= dec_ill_s;
            skid_tag_r   <= IN_TAG;
            in_ready_r   <= 1'b0;
        end else begin
            in_ready_r   <= ~skid_valid_r;
        end
    end

    assign OUT_VALID = out_valid_r;
    assign IMMEDIATE = out_imm_r;
    assign FORMAT    = out_fmt_r;
    assign ILLEGAL   = out_ill_r;
    assign OUT_TAG   = out_tag_r;

endmodule

// File: tb/tb_immediate_generator_pipe.sv
module tb_immediate_generator_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] instruction;
    logic [7:0]  in_tag;

    logic        rdy32, v32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [7:0]  tag32;
    logic        rdy64, v64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [7:0]  tag64;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    bit   busy;

    always #5 clk = ~clk;

    immediate_generator_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .CLK(clk), .RESET(reset), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(rdy32), .INSTRUCTION(instruction), .IN_TAG(in_tag),
        .OUT_VALID(v32), .OUT_READY(out_ready), .IMMEDIATE(imm32), .FORMAT(fmt32),
        .ILLEGAL(ill32), .OUT_TAG(tag32)
    );

    immediate_generator_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .CLK(clk), .RESET(reset), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(rdy64), .INSTRUCTION(instruction), .IN_TAG(in_tag),
        .OUT_VALID(v64), .OUT_READY(out_ready), .IMMEDIATE(imm64), .FORMAT(fmt64),
        .ILLEGAL(ill64), .OUT_TAG(tag64)
    );

    task automatic check_value(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference decode written from the ISA field layouts with signed casts.
    function automatic exp_t model(input logic [31:0] i, input logic [7:0] tg, input bit x64);
        exp_t e;
        logic signed [63:0] s;
        logic [2:0] f3;
        f3 = i[14:12];
        s = 64'sd0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        e.tag = tg;
        case (i[6:0])
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.fmt = 3'd6;
                    if (x64) s = 64'(i[25:20]);
                    else if (i[25]) e.ill = 1'b1;
                    else s = 64'(i[24:20]);
                end else begin
                    e.fmt = 3'd1;
                    s = 64'($signed(i[31:20]));
                end
            end
            7'h03, 7'h67: begin e.fmt = 3'd1; s = 64'($signed(i[31:20])); end
            7'h23: begin e.fmt = 3'd2; s = 64'($signed({i[31:25], i[11:7]})); end
            7'h63: begin e.fmt = 3'd3; s = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
            7'h37, 7'h17: begin e.fmt = 3'd4; s = 64'($signed({i[31:12], 12'd0})); end
            7'h6f: begin e.fmt = 3'd5; s = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
            7'h73: begin
                if (f3 >= 3'd5) begin e.fmt = 3'd7; s = 64'(i[19:15]); end
            end
            default: ;
        endcase
        e.imm = x64 ? s : {32'd0, s[31:0]};
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on every output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (reset || flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (v32 && out_ready) begin
                if (q32.size() == 0) check_value("out32_unexpected", 64'd1, 64'd0);
                else begin
                    e = q32.pop_front();
                    check_value("imm32", {32'd0, imm32}, e.imm);
                    check_value("fmt32", 64'(fmt32), 64'(e.fmt));
                    check_value("ill32", 64'(ill32), 64'(e.ill));
                    check_value("tag32", 64'(tag32), 64'(e.tag));
                end
            end
            if (v64 && out_ready) begin
                if (q64.size() == 0) check_value("out64_unexpected", 64'd1, 64'd0);
                else begin
                    e = q64.pop_front();
                    check_value("imm64", imm64, e.imm);
                    check_value("fmt64", 64'(fmt64), 64'(e.fmt));
                    check_value("ill64", 64'(ill64), 64'(e.ill));
                    check_value("tag64", 64'(tag64), 64'(e.tag));
                end
            end
            if (in_valid && rdy32) q32.push_back(model(instruction, in_tag, 1'b0));
            if (in_valid && rdy64) q64.push_back(model(instruction, in_tag, 1'b1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction and hold it until the edge that accepts it.
    task automatic offer(input logic [31:0] ins, input logic [7:0] tg);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        instruction = ins;
        in_tag = tg;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            done = rdy32;
            step();
        end
        in_valid = 1'b0;
        if (!done) check_value("offer_timeout", 64'd0, 64'd1);
    endtask

    // One instruction through an idle pipe with literal expected values.
    task automatic directed(input logic [31:0] ins, input logic [7:0] tg,
                            input logic [31:0] e32, input logic [63:0] e64,
                            input logic [2:0] ef, input logic eil32);
        offer(ins, tg);
        @(negedge clk);
        check_value("lat_valid32", 64'(v32), 64'd1);
        check_value("lit_imm32", {32'd0, imm32}, {32'd0, e32});
        check_value("lit_imm64", imm64, e64);
        check_value("lit_fmt", 64'(fmt32), 64'(ef));
        check_value("lit_ill32", 64'(ill32), 64'(eil32));
        check_value("lit_tag", 64'(tag32), 64'(tg));
        step();
    endtask

    task automatic fill_two();
        out_ready = 1'b0;
        offer(32'hFFF00093, 8'h11);
        offer(32'h02101093, 8'h12);
        @(negedge clk);
        check_value("full_ready", 64'(rdy32), 64'd0);
        check_value("full_tag", 64'(tag32), 64'h11);
        step();
    endtask

    logic [31:0] vlist [10];

    initial begin
        vlist[0] = 32'hFFF00093; vlist[1] = 32'hFE000EE3; vlist[2] = 32'h02101093;
        vlist[3] = 32'h3402D073; vlist[4] = 32'h800002B7; vlist[5] = 32'hFE112C23;
        vlist[6] = 32'h8000006F; vlist[7] = 32'h00000073; vlist[8] = 32'h00B50533;
        vlist[9] = 32'h0045D293;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instruction = 32'd0; in_tag = 8'd0;
        step(); step();
        @(negedge clk);
        check_value("rst_in_ready", 64'(rdy32), 64'd0);
        check_value("rst_valid", 64'(v32), 64'd0);
        reset = 1'b0;
        #1;
        check_value("post_rst_ready", 64'(rdy32), 64'd1);
        check_value("post_rst_imm", {32'd0, imm32}, 64'd0);
        check_value("post_rst_fmt", 64'(fmt32), 64'd0);
        check_value("post_rst_tag", 64'(tag32), 64'd0);
        step();

        // Test-plan vectors
        directed(32'hFFF00093, 8'h01, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        directed(32'hFE000EE3, 8'h02, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
        directed(32'h02101093, 8'h03, 32'h00000000, 64'h21, 3'd6, 1'b1);
        directed(32'h3402D073, 8'h5A, 32'h5, 64'h5, 3'd7, 1'b0);
        directed(32'h800002B7, 8'h04, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0);

        // Backpressure: 1 held in output, 2 in skid, 3 blocked
        out_ready = 1'b0;
        offer(32'hFFF00093, 8'd1);
        offer(32'hFE000EE3, 8'd2);
        in_valid = 1'b1; instruction = 32'h3402D073; in_tag = 8'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_value("bp_in_ready", 64'(rdy32), 64'd0);
            check_value("bp_hold_tag", 64'(tag32), 64'd1);
            check_value("bp_hold_imm", {32'd0, imm32}, 64'hFFFFFFFF);
            step();
        end
        out_ready = 1'b1;
        begin
            bit done;
            done = 1'b0;
            for (int k = 0; k < 10 && !done; k++) begin
                @(negedge clk);
                done = rdy32;
                step();
            end
            if (!done) check_value("bp_accept3", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10 && q32.size() != 0; k++) step();
        check_value("bp_drained", 64'(q32.size()), 64'd0);

        // Flush with buffer full and a new offer in the same cycle
        fill_two();
        in_valid = 1'b1; instruction = 32'h0045D293; in_tag = 8'h13; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_value("flush_valid", 64'(v32), 64'd0);
        check_value("flush_ready", 64'(rdy32), 64'd1);
        out_ready = 1'b1;
        step(); step(); step();
        check_value("flush_stays_empty", 64'(v64), 64'd0);

        // Reset mid-stream with buffer full
        fill_two();
        in_valid = 1'b1; instruction = 32'h0045D293; in_tag = 8'h14; reset = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check_value("rst2_ready", 64'(rdy32), 64'd0);
        check_value("rst2_valid", 64'(v32), 64'd0);
        check_value("rst2_imm", imm64, 64'd0);
        check_value("rst2_fmt", 64'(fmt64), 64'd0);
        check_value("rst2_ill", 64'(ill32), 64'd0);
        check_value("rst2_tag", 64'(tag64), 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        check_value("rst2_after_ready", 64'(rdy32), 64'd1);
        step(); step();
        check_value("rst2_stays_empty", 64'(v32), 64'd0);

        // Random stream with random backpressure
        busy = 1'b1;
        fork
            begin
                for (int n = 0; n < 40; n++) offer(vlist[$urandom_range(0, 9)], 8'(n + 100));
                busy = 1'b0;
            end
            begin
                while (busy) begin
                    step();
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (q32.size() != 0 || q64.size() != 0); k++) step();
        check_value("final_q32_empty", 64'(q32.size()), 64'd0);
        check_value("final_q64_empty", 64'(q64.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
